// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI4 RAM responder.
package axi_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } wr_state_e;

  typedef enum logic {
    RIdle,
    RData
  } rd_state_e;

endpackage

// File: rtl/axi_burst_addr_next.sv
// Next-beat address and per-beat legality for one AXI burst engine.
module axi_burst_addr_next
  import axi_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 31,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WIN_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  burst_err_o,
  output logic                  oob_o
);

  localparam int unsigned LaneBits = $clog2(DATA_WIDTH / 8);
  localparam int unsigned ArrBits  = DEPTH_LOG2 + LaneBits;

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  always_comb begin
    incr        = ADDR_WIDTH'(1) << size_i;
    wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    wrap_ok     = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    burst_err_o = (size_i > 3'(LaneBits)) || (burst_i == RSVD) ||
                  ((burst_i == WRAP) && !wrap_ok);
    oob_o       = |(addr_i[WIN_WIDTH-1:0] >> ArrBits);

    next_addr_o = addr_i;
    case (burst_i)
      INCR: next_addr_o = addr_i + incr;
      WRAP: begin
        // An illegal wrap length degrades to INCR.
        if (wrap_ok) begin
          next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + incr) & wrap_mask);
        end else begin
          next_addr_o = addr_i + incr;
        end
      end
      default: next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by an on-chip word array, with independent read and write engines.
module axi_ram_slave
  import axi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 31,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned WIN_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned Lanes    = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(Lanes);
  localparam int unsigned ArrBits  = DEPTH_LOG2 + LaneBits;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

  // ---------------- write engine ----------------
  wr_state_e             w_state_q;
  logic [ID_WIDTH-1:0]   w_id_q, bid_q;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_next_addr;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q, bresp_q;
  logic                  w_err_q, awready_q, wready_q, bvalid_q;
  logic                  w_burst_err, w_oob, w_beat_err, w_fire, w_last_beat, w_err_now;

  axi_burst_addr_next #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .WIN_WIDTH (WIN_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_w_addr (
    .addr_i     (w_addr_q),
    .len_i      (w_len_q),
    .size_i     (w_size_q),
    .burst_i    (w_burst_q),
    .next_addr_o(w_next_addr),
    .burst_err_o(w_burst_err),
    .oob_o      (w_oob)
  );

  assign w_beat_err  = w_burst_err | w_oob;
  assign w_fire      = (w_state_q == WData) && s_axi_wvalid && wready_q;
  assign w_last_beat = (w_cnt_q == w_len_q);
  // The burst length comes from awlen; wlast only contributes to the error flag.
  assign w_err_now   = w_err_q | w_beat_err | (s_axi_wlast != w_last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        WIdle: begin
          if (s_axi_awvalid && awready_q) begin
            w_id_q    <= s_axi_awid;
            w_addr_q  <= s_axi_awaddr;
            w_len_q   <= s_axi_awlen;
            w_size_q  <= s_axi_awsize;
            w_burst_q <= s_axi_awburst;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= WData;
          end else begin
            awready_q <= 1'b1;
          end
        end
        WData: begin
          if (w_fire) begin
            w_addr_q <= w_next_addr;
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_err_q  <= w_err_now;
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= w_err_now ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_beat_err) begin
      for (int b = 0; b < Lanes; b++) begin
        if (s_axi_wstrb[b]) mem[w_addr_q[ArrBits-1:LaneBits]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

  // ---------------- read engine ----------------
  rd_state_e             r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_cur_addr, r_next_addr;
  logic [7:0]            r_len_q, r_cur_len, r_cnt_q;
  logic [2:0]            r_size_q, r_cur_size;
  logic [1:0]            r_burst_q, r_cur_burst, rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q, r_word;
  logic                  arready_q, rvalid_q, rlast_q;
  logic                  r_burst_err, r_oob, r_beat_err;

  // In idle the address calculator looks at the AR channel so beat 0 loads on the handshake.
  always_comb begin
    if (r_state_q == RIdle) begin
      r_cur_addr  = s_axi_araddr;
      r_cur_len   = s_axi_arlen;
      r_cur_size  = s_axi_arsize;
      r_cur_burst = s_axi_arburst;
    end else begin
      r_cur_addr  = r_addr_q;
      r_cur_len   = r_len_q;
      r_cur_size  = r_size_q;
      r_cur_burst = r_burst_q;
    end
  end

  axi_burst_addr_next #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .WIN_WIDTH (WIN_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_r_addr (
    .addr_i     (r_cur_addr),
    .len_i      (r_cur_len),
    .size_i     (r_cur_size),
    .burst_i    (r_cur_burst),
    .next_addr_o(r_next_addr),
    .burst_err_o(r_burst_err),
    .oob_o      (r_oob)
  );

  assign r_beat_err = r_burst_err | r_oob;
  assign r_word     = mem[r_cur_addr[ArrBits-1:LaneBits]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (s_axi_arvalid && arready_q) begin
            r_len_q   <= s_axi_arlen;
            r_size_q  <= s_axi_arsize;
            r_burst_q <= s_axi_arburst;
            rid_q     <= s_axi_arid;
            r_addr_q  <= r_next_addr;
            r_cnt_q   <= '0;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_beat_err ? '0 : r_word;
            rresp_q   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q   <= (s_axi_arlen == 8'd0);
            arready_q <= 1'b0;
            r_state_q <= RData;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RData: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              r_addr_q <= r_next_addr;
              r_cnt_q  <= r_cnt_q + 8'd1;
              rdata_q  <= r_beat_err ? '0 : r_word;
              rresp_q  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
              rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;

endmodule
